// File: rtl/clk_freq_meter.sv
// Counts synchronized rising edges of sig_in over a GATE_CYCLES window of clk_in
// and reports the count, tolerance status, saturation and loss-of-signal once per window.
module clk_freq_meter #(
  parameter int unsigned GATE_CYCLES = 500000,
  parameter int unsigned GATE_W      = 20,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned EXP_COUNT   = 100,
  parameter int unsigned TOL         = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic             busy,
  output logic [CNT_W-1:0] freq_count,
  output logic             count_valid,
  output logic             in_range,
  output logic             overflow,
  output logic             sig_lost
);

  typedef enum logic [1:0] {IDLE, GATE, REPORT} state_t;

  localparam logic [31:0]       LO_BOUND  = (TOL > EXP_COUNT) ? 32'd0 : 32'(EXP_COUNT - TOL);
  localparam logic [31:0]       HI_BOUND  = 32'(EXP_COUNT + TOL);
  localparam logic [GATE_W-1:0] LAST_TICK = GATE_W'(GATE_CYCLES - 1);

  state_t            state_q;
  logic              s1_q, s2_q, s3_q;
  logic [GATE_W-1:0] timer_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              edge_pulse;
  logic              win_in_range;

  assign edge_pulse = s2_q & ~s3_q;

  // Saturating increment; ovf is sticky for the rest of the window.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (edge_pulse) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + 1'b1;
    end
  end

  assign win_in_range = !ovf_d && (32'(cnt_d) >= LO_BOUND) && (32'(cnt_d) <= HI_BOUND);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      timer_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      busy        <= 1'b0;
      freq_count  <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      overflow    <= 1'b0;
      sig_lost    <= 1'b0;
    end else begin
      s1_q        <= sig_in;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      count_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          if (enable) begin
            state_q <= GATE;
            busy    <= 1'b1;
          end
        end
        GATE: begin
          if (!enable) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            timer_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end else if (timer_q == LAST_TICK) begin
            // The final gate cycle's edge is folded in via cnt_d/ovf_d.
            state_q     <= REPORT;
            busy        <= 1'b0;
            count_valid <= 1'b1;
            freq_count  <= cnt_d;
            overflow    <= ovf_d;
            sig_lost    <= (cnt_d == '0);
            in_range    <= win_in_range;
            timer_q     <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
          end
        end
        REPORT: begin
          timer_q <= '0;
          cnt_q   <= '0;
          ovf_q   <= 1'b0;
          if (enable) begin
            state_q <= GATE;
            busy    <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter with a short gate window and small counter.
module tb_clk_freq_meter;

  localparam int GC  = 100;
  localparam int CW  = 5;

  logic          clk_in = 1'b0;
  logic          rst    = 1'b1;
  logic          sig_in = 1'b0;
  logic          enable = 1'b0;
  logic          busy;
  logic [CW-1:0] freq_count;
  logic          count_valid;
  logic          in_range;
  logic          overflow;
  logic          sig_lost;

  int checks   = 0;
  int failures = 0;
  int sig_period = 0;

  clk_freq_meter #(
    .GATE_CYCLES(GC), .GATE_W(8), .CNT_W(CW), .EXP_COUNT(10), .TOL(1)
  ) dut (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .enable(enable),
    .busy(busy), .freq_count(freq_count), .count_valid(count_valid),
    .in_range(in_range), .overflow(overflow), .sig_lost(sig_lost)
  );

  always #5 clk_in = ~clk_in;

  // Square-wave source, updated 3 ns after each clk_in edge so it is never edge-aligned.
  initial begin : sig_gen
    int ph;
    ph = 0;
    forever begin
      @(posedge clk_in);
      #3;
      if (sig_period == 0) begin
        sig_in = 1'b0;
        ph = 0;
      end else begin
        ph = ph + 1;
        if (ph >= sig_period) ph = 0;
        sig_in = (ph < sig_period / 2);
      end
    end
  end

  task automatic wait_valid(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk_in);
      if (count_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk_in);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (freq_count !== '0) begin failures++; $display("FAIL rst_freq got=%0d exp=0", freq_count); end
    checks++; if (count_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", count_valid); end
    checks++; if (in_range !== 1'b0) begin failures++; $display("FAIL rst_in_range got=%0b exp=0", in_range); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%0b exp=0", overflow); end
    checks++; if (sig_lost !== 1'b0) begin failures++; $display("FAIL rst_sig_lost got=%0b exp=0", sig_lost); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int n;
    sig_period = 10;
    repeat (20) @(negedge clk_in);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", busy); end
    enable = 1'b1;
    wait_valid(200, n);
    checks++; if (n != 101) begin failures++; $display("FAIL nom_first_latency got=%0d exp=101", n); end
    checks++; if (freq_count < 9 || freq_count > 11) begin failures++; $display("FAIL nom_count got=%0d exp=9..11", freq_count); end
    checks++; if (in_range !== 1'b1) begin failures++; $display("FAIL nom_in_range got=%0b exp=1", in_range); end
    checks++; if (sig_lost !== 1'b0) begin failures++; $display("FAIL nom_sig_lost got=%0b exp=0", sig_lost); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL nom_overflow got=%0b exp=0", overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL nom_busy_report got=%0b exp=0", busy); end
    @(negedge clk_in);
    checks++; if (count_valid !== 1'b0) begin failures++; $display("FAIL nom_pulse_width got=%0b exp=0", count_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL nom_busy_gate got=%0b exp=1", busy); end
    wait_valid(200, n);
    checks++; if (n != 100) begin failures++; $display("FAIL nom_period got=%0d exp=100", n); end
    checks++; if (freq_count < 9 || freq_count > 11) begin failures++; $display("FAIL nom_count2 got=%0d exp=9..11", freq_count); end
  endtask

  task automatic test_period7();
    int n;
    sig_period = 7;
    wait_valid(200, n);
    wait_valid(200, n);
    checks++; if (n != 101) begin failures++; $display("FAIL p7_period got=%0d exp=101", n); end
    checks++; if (freq_count < 14 || freq_count > 15) begin failures++; $display("FAIL p7_count got=%0d exp=14..15", freq_count); end
    checks++; if (in_range !== 1'b0) begin failures++; $display("FAIL p7_in_range got=%0b exp=0", in_range); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL p7_overflow got=%0b exp=0", overflow); end
  endtask

  task automatic test_sig_lost();
    int n;
    enable = 1'b0;
    sig_period = 0;
    repeat (10) @(negedge clk_in);
    enable = 1'b1;
    wait_valid(200, n);
    checks++; if (n != 101) begin failures++; $display("FAIL lost_first got=%0d exp=101", n); end
    checks++; if (freq_count !== '0) begin failures++; $display("FAIL lost_count got=%0d exp=0", freq_count); end
    checks++; if (sig_lost !== 1'b1) begin failures++; $display("FAIL lost_flag got=%0b exp=1", sig_lost); end
    checks++; if (in_range !== 1'b0) begin failures++; $display("FAIL lost_in_range got=%0b exp=0", in_range); end
    wait_valid(200, n);
    checks++; if (n != 101) begin failures++; $display("FAIL lost_second got=%0d exp=101", n); end
    checks++; if (sig_lost !== 1'b1) begin failures++; $display("FAIL lost_flag2 got=%0b exp=1", sig_lost); end
  endtask

  task automatic test_overflow();
    int n;
    enable = 1'b0;
    sig_period = 2;
    repeat (10) @(negedge clk_in);
    enable = 1'b1;
    wait_valid(200, n);
    checks++; if (n != 101) begin failures++; $display("FAIL ovf_latency got=%0d exp=101", n); end
    checks++; if (freq_count !== 5'd31) begin failures++; $display("FAIL ovf_count got=%0d exp=31", freq_count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    checks++; if (in_range !== 1'b0) begin failures++; $display("FAIL ovf_in_range got=%0b exp=0", in_range); end
    checks++; if (sig_lost !== 1'b0) begin failures++; $display("FAIL ovf_sig_lost got=%0b exp=0", sig_lost); end
    wait_valid(200, n);
    checks++; if (freq_count !== 5'd31) begin failures++; $display("FAIL ovf_count2 got=%0d exp=31", freq_count); end
  endtask

  task automatic test_abort();
    int n;
    logic [CW-1:0] prev;
    enable = 1'b0;
    sig_period = 10;
    repeat (10) @(negedge clk_in);
    enable = 1'b1;
    wait_valid(200, n);
    prev = freq_count;
    checks++; if (prev < 9 || prev > 11) begin failures++; $display("FAIL abort_pre_count got=%0d exp=9..11", prev); end
    repeat (60) @(negedge clk_in);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%0b exp=1", busy); end
    enable = 1'b0;
    @(negedge clk_in);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy_after got=%0b exp=0", busy); end
    wait_valid(150, n);
    checks++; if (n != -1) begin failures++; $display("FAIL abort_no_valid got=%0d exp=-1", n); end
    checks++; if (freq_count !== prev) begin failures++; $display("FAIL abort_hold got=%0d exp=%0d", freq_count, prev); end
    checks++; if (in_range !== 1'b1) begin failures++; $display("FAIL abort_hold_range got=%0b exp=1", in_range); end
    enable = 1'b1;
    wait_valid(200, n);
    checks++; if (n != 101) begin failures++; $display("FAIL abort_restart got=%0d exp=101", n); end
    checks++; if (freq_count < 9 || freq_count > 11) begin failures++; $display("FAIL abort_restart_count got=%0d exp=9..11", freq_count); end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (30) @(negedge clk_in);
    #2 rst = 1'b1;
    #1;
    checks++; if (freq_count !== '0) begin failures++; $display("FAIL mid_rst_freq got=%0d exp=0", freq_count); end
    checks++; if (in_range !== 1'b0) begin failures++; $display("FAIL mid_rst_in_range got=%0b exp=0", in_range); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%0b exp=0", busy); end
    @(negedge clk_in);
    rst = 1'b0;
    wait_valid(200, n);
    checks++; if (n != 101) begin failures++; $display("FAIL mid_rst_latency got=%0d exp=101", n); end
    checks++; if (freq_count < 9 || freq_count > 11) begin failures++; $display("FAIL mid_rst_count got=%0d exp=9..11", freq_count); end
    checks++; if (in_range !== 1'b1) begin failures++; $display("FAIL mid_rst_in_range2 got=%0b exp=1", in_range); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_period7();
    test_sig_lost();
    test_overflow();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
